// File: rtl/vga_fml_pkg.sv
// Shared definitions for the VGA/CPU FML arbiter: state encoding and bus widths.
package vga_fml_pkg;

  localparam int FML_DW = 16;  // FML data width
  localparam int FML_SW = 2;   // FML byte-select width

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_VID  = 2'd1,
    ARB_CPU  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_fml_arbiter.sv
// Shares one FML master between the VGA sequencer fetch port (fixed priority)
// and the CPU framebuffer port. A saturating starvation counter forces a CPU
// slot after VID_MAX consecutive video grants while the CPU is waiting.
// Master-side outputs are registered; acks and read data return combinationally.
module vga_fml_arbiter
  import vga_fml_pkg::*;
#(
  parameter int ADR_W   = 17,
  parameter int VID_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  // video fetch port (read only)
  input  logic [ADR_W-1:0]  vid_adr_i,
  input  logic              vid_stb_i,
  output logic [FML_DW-1:0] vid_dat_o,
  output logic              vid_ack_o,
  // CPU framebuffer port
  input  logic [ADR_W-1:0]  cpu_adr_i,
  input  logic              cpu_stb_i,
  input  logic              cpu_we_i,
  input  logic [FML_SW-1:0] cpu_sel_i,
  input  logic [FML_DW-1:0] cpu_dat_i,
  output logic [FML_DW-1:0] cpu_dat_o,
  output logic              cpu_ack_o,
  // FML master
  output logic [ADR_W-1:0]  fml_adr_o,
  output logic              fml_stb_o,
  output logic              fml_we_o,
  output logic [FML_SW-1:0] fml_sel_o,
  output logic [FML_DW-1:0] fml_dw_o,
  input  logic [FML_DW-1:0] fml_dr_i,
  input  logic              fml_ack_i
);

  localparam logic [3:0] VID_MAX_C = 4'(VID_MAX);

  arb_state_e        state_reg, state_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [ADR_W-1:0]  adr_reg, adr_next;
  logic              stb_reg, stb_next;
  logic              we_reg, we_next;
  logic [FML_SW-1:0] sel_reg, sel_next;
  logic [FML_DW-1:0] dw_reg, dw_next;

  logic cpu_starved;
  assign cpu_starved = cpu_stb_i && (starve_cnt_reg == VID_MAX_C);

  // State, starvation counter and registered master outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      starve_cnt_reg <= 4'd0;
      adr_reg        <= '0;
      stb_reg        <= 1'b0;
      we_reg         <= 1'b0;
      sel_reg        <= '0;
      dw_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      adr_reg        <= adr_next;
      stb_reg        <= stb_next;
      we_reg         <= we_next;
      sel_reg        <= sel_next;
      dw_reg         <= dw_next;
    end
  end

  // Grant decision in IDLE, transaction hold until the slave acknowledges.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    adr_next        = adr_reg;
    stb_next        = stb_reg;
    we_next         = we_reg;
    sel_next        = sel_reg;
    dw_next         = dw_reg;

    case (state_reg)
      ARB_IDLE: begin
        // Starvation history only matters while the CPU is actually waiting.
        if (!cpu_stb_i) begin
          starve_cnt_next = 4'd0;
        end
        if (vid_stb_i && !cpu_starved) begin
          state_next = ARB_VID;
          adr_next   = vid_adr_i;
          we_next    = 1'b0;
          sel_next   = 2'b11;
          stb_next   = 1'b1;
          if (cpu_stb_i && (starve_cnt_reg != VID_MAX_C)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end else if (cpu_stb_i) begin
          state_next      = ARB_CPU;
          adr_next        = cpu_adr_i;
          we_next         = cpu_we_i;
          sel_next        = cpu_sel_i;
          dw_next         = cpu_dat_i;
          stb_next        = 1'b1;
          starve_cnt_next = 4'd0;
        end
      end
      ARB_VID, ARB_CPU: begin
        if (fml_ack_i) begin
          stb_next   = 1'b0;
          state_next = ARB_IDLE;
        end
      end
      default: begin
        stb_next   = 1'b0;
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign fml_adr_o = adr_reg;
  assign fml_stb_o = stb_reg;
  assign fml_we_o  = we_reg;
  assign fml_sel_o = sel_reg;
  assign fml_dw_o  = dw_reg;

  // Acks are steered by the owner of the in-flight transaction; an ack in IDLE is dropped.
  assign vid_ack_o = fml_ack_i && (state_reg == ARB_VID);
  assign cpu_ack_o = fml_ack_i && (state_reg == ARB_CPU);
  assign vid_dat_o = fml_dr_i;
  assign cpu_dat_o = fml_dr_i;

endmodule
